// File: rtl/tow_game_if.sv
// Signal bundle between the tug-of-war game controller and its board.
// The board side drives the ticks and buttons; the controller drives the displays.
interface tow_game_if #(
  parameter int NLED = 9
);
  logic            slowen;
  logic            pb_l;
  logic            pb_r;
  logic            start;
  logic [NLED-1:0] leds;
  logic [3:0]      pos;
  logic [1:0]      state;
  logic [3:0]      cd;
  logic [1:0]      winner;
  logic [3:0]      score_l;
  logic [3:0]      score_r;

  modport master (
    output slowen, pb_l, pb_r, start,
    input  leds, pos, state, cd, winner, score_l, score_r
  );

  modport slave (
    input  slowen, pb_l, pb_r, start,
    output leds, pos, state, cd, winner, score_l, score_r
  );
endinterface

// File: rtl/tow_game_fsm.sv
// Tug-of-war game controller: button synchronisers, edge detect, and an
// IDLE/COUNTDOWN/PLAY/WIN machine driving the rope LEDs, countdown and scores.
module tow_game_fsm #(
  parameter int NLED        = 9,
  parameter int COUNT_TICKS = 3,
  parameter int WIN_TICKS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  tow_game_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    WIN       = 2'd3
  } state_t;

  localparam logic [3:0]      CTR     = 4'((NLED - 1) / 2);
  localparam logic [3:0]      LAST    = 4'(NLED - 1);
  localparam logic [3:0]      HI      = 4'(NLED - 2);
  localparam logic [3:0]      CD_INIT = 4'(COUNT_TICKS);
  localparam logic [3:0]      WIN_END = 4'(WIN_TICKS);
  localparam logic [NLED-1:0] ONE     = {{(NLED-1){1'b0}}, 1'b1};

  // Bit order in the synchroniser vectors: {start, pb_r, pb_l}.
  logic [2:0] sync1, sync2, prev, edges;
  logic       pbl_e, pbr_e, start_e;

  state_t          state_q, state_d;
  logic [3:0]      pos_q, pos_d;
  logic [3:0]      cd_q, cd_d;
  logic [1:0]      winner_q, winner_d;
  logic [3:0]      score_l_q, score_l_d;
  logic [3:0]      score_r_q, score_r_d;
  logic            flash_q, flash_d;
  logic [3:0]      tick_q, tick_d;
  logic [NLED-1:0] leds_q, leds_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {bus.start, bus.pb_r, bus.pb_l};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edges   = sync2 & ~prev;
  assign pbl_e   = edges[0];
  assign pbr_e   = edges[1];
  assign start_e = edges[2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pos_q     <= CTR;
      cd_q      <= '0;
      winner_q  <= 2'b00;
      score_l_q <= '0;
      score_r_q <= '0;
      flash_q   <= 1'b0;
      tick_q    <= '0;
      leds_q    <= ONE << CTR;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cd_q      <= cd_d;
      winner_q  <= winner_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      flash_q   <= flash_d;
      tick_q    <= tick_d;
      leds_q    <= leds_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cd_d      = cd_q;
    winner_d  = winner_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    flash_d   = flash_q;
    tick_d    = tick_q;

    unique case (state_q)
      IDLE: begin
        pos_d = CTR;
        if (start_e) begin
          state_d  = COUNTDOWN;
          cd_d     = CD_INIT;
          winner_d = 2'b00;
        end
      end

      COUNTDOWN: begin
        // A false start nudges the rope but can never end the game early.
        if (pbl_e && !pbr_e && pos_q > 4'd1)      pos_d = pos_q - 4'd1;
        else if (pbr_e && !pbl_e && pos_q < HI)   pos_d = pos_q + 4'd1;
        if (bus.slowen) begin
          if (cd_q == 4'd1) begin
            state_d = PLAY;
            cd_d    = 4'd0;
          end else begin
            cd_d = cd_q - 4'd1;
          end
        end
      end

      PLAY: begin
        if (pbl_e && !pbr_e)      pos_d = pos_q + 4'd1;
        else if (pbr_e && !pbl_e) pos_d = pos_q - 4'd1;
        if (pos_d == LAST) begin
          state_d  = WIN;
          winner_d = 2'b01;
          flash_d  = 1'b1;
          tick_d   = 4'd0;
          if (score_l_q != 4'hF) score_l_d = score_l_q + 4'd1;
        end else if (pos_d == 4'd0) begin
          state_d  = WIN;
          winner_d = 2'b10;
          flash_d  = 1'b1;
          tick_d   = 4'd0;
          if (score_r_q != 4'hF) score_r_d = score_r_q + 4'd1;
        end
      end

      WIN: begin
        if (bus.slowen) begin
          flash_d = ~flash_q;
          tick_d  = tick_q + 4'd1;
          if (tick_d == WIN_END) begin
            state_d = IDLE;
            pos_d   = CTR;
            flash_d = 1'b0;
          end
        end
      end
    endcase
  end

  // The LED pattern is decoded from next-state values so it can be registered.
  always_comb begin
    if (state_d == WIN) leds_d = {NLED{flash_d}};
    else                leds_d = ONE << pos_d;
  end

  assign bus.state   = state_q;
  assign bus.pos     = pos_q;
  assign bus.cd      = cd_q;
  assign bus.winner  = winner_q;
  assign bus.score_l = score_l_q;
  assign bus.score_r = score_r_q;
  assign bus.leds    = leds_q;

endmodule

// File: tb/tb_tow_game_fsm.sv
// Self-checking bench for tow_game_fsm: directed table, corner sequences,
// and a random run compared against a rule-level game model.
module tb_tow_game_fsm;
  localparam int NLED        = 9;
  localparam int COUNT_TICKS = 3;
  localparam int WIN_TICKS   = 4;
  localparam int CTR         = (NLED - 1) / 2;

  localparam int S_IDLE = 0, S_CD = 1, S_PLAY = 2, S_WIN = 3;

  localparam logic [NLED-1:0] OH4  = 9'b000010000;
  localparam logic [NLED-1:0] ALL1 = '1;
  localparam logic [NLED-1:0] ALL0 = '0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tow_game_if #(.NLED(NLED)) bus ();

  tow_game_fsm #(
    .NLED(NLED), .COUNT_TICKS(COUNT_TICKS), .WIN_TICKS(WIN_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural game model ----------------
  int m_state, m_pos, m_cd, m_win, m_scl, m_scr, m_tick;
  bit m_flash;
  // Last three sampled button levels, oldest first.
  bit hl[$] = '{0, 0, 0};
  bit hr[$] = '{0, 0, 0};
  bit hs[$] = '{0, 0, 0};

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  task automatic model_step(input bit l, input bit r, input bit s, input bit sl, input bit rn);
    bit el, er, es;
    if (!rn) begin
      m_state = S_IDLE; m_pos = CTR; m_cd = 0; m_win = 0;
      m_scl = 0; m_scr = 0; m_flash = 0; m_tick = 0;
      hl = '{0, 0, 0}; hr = '{0, 0, 0}; hs = '{0, 0, 0};
      return;
    end
    // A press first seen at edge k acts at edge k+2.
    el = hl[1] && !hl[0];
    er = hr[1] && !hr[0];
    es = hs[1] && !hs[0];
    void'(hl.pop_front()); hl.push_back(l);
    void'(hr.pop_front()); hr.push_back(r);
    void'(hs.pop_front()); hs.push_back(s);
    case (m_state)
      S_IDLE: begin
        m_pos = CTR;
        if (es) begin m_state = S_CD; m_cd = COUNT_TICKS; m_win = 0; end
      end
      S_CD: begin
        if (el && !er) m_pos = imax(1, m_pos - 1);
        if (er && !el) m_pos = imin(NLED - 2, m_pos + 1);
        if (sl) begin
          m_cd = m_cd - 1;
          if (m_cd == 0) m_state = S_PLAY;
        end
      end
      S_PLAY: begin
        m_pos = m_pos + (el ? 1 : 0) - (er ? 1 : 0);
        if (m_pos == NLED - 1 || m_pos == 0) begin
          m_state = S_WIN; m_flash = 1; m_tick = 0;
          if (m_pos != 0) begin m_win = 1; m_scl = imin(15, m_scl + 1); end
          else            begin m_win = 2; m_scr = imin(15, m_scr + 1); end
        end
      end
      default: begin
        if (sl) begin
          m_flash = !m_flash;
          m_tick++;
          if (m_tick == WIN_TICKS) begin m_state = S_IDLE; m_pos = CTR; m_flash = 0; end
        end
      end
    endcase
  endtask

  function automatic logic [NLED-1:0] model_leds();
    logic [NLED-1:0] one = 1;
    if (m_state == S_WIN) return m_flash ? ALL1 : ALL0;
    return one << m_pos;
  endfunction

  task automatic check_model(input int cyc);
    check($sformatf("rnd%0d state", cyc),   bus.state,   m_state);
    check($sformatf("rnd%0d pos", cyc),     bus.pos,     m_pos);
    check($sformatf("rnd%0d cd", cyc),      bus.cd,      m_cd);
    check($sformatf("rnd%0d winner", cyc),  bus.winner,  m_win);
    check($sformatf("rnd%0d score_l", cyc), bus.score_l, m_scl);
    check($sformatf("rnd%0d score_r", cyc), bus.score_r, m_scr);
    check($sformatf("rnd%0d leds", cyc),    bus.leds,    model_leds());
  endtask

  // One clock: apply inputs, let the edge happen, sample 1 ns later.
  task automatic tick(input bit l, input bit r, input bit s, input bit sl);
    bus.pb_l = l; bus.pb_r = r; bus.start = s; bus.slowen = sl;
    @(posedge clk);
    model_step(l, r, s, sl, rst);
    #1;
  endtask

  task automatic press(input bit l, input bit r, input bit s, input bit sl, input int nw);
    tick(l, r, s, sl);
    repeat (nw) tick(0, 0, 0, 0);
  endtask

  // Start from IDLE and run the countdown into PLAY.
  task automatic start_game(input string tag);
    press(0, 0, 1, 0, 2);
    check({tag, " cd state"}, bus.state, S_CD);
    check({tag, " cd value"}, bus.cd, COUNT_TICKS);
    repeat (COUNT_TICKS) tick(0, 0, 0, 1);
    check({tag, " play state"}, bus.state, S_PLAY);
  endtask

  typedef struct {
    bit              l, r, s, slw;
    int              nw;
    int              st, ps, cd, wn, scl, scr;
    logic [NLED-1:0] led;
  } vec_t;

  vec_t vecs[23];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pb_l = 0; bus.pb_r = 0; bus.start = 0; bus.slowen = 0;

    // Reset and idle.
    rst = 0;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    rst = 1;
    repeat (5) tick(0, 0, 0, 0);
    check("reset state",   bus.state,   0);
    check("reset pos",     bus.pos,     CTR);
    check("reset leds",    bus.leds,    OH4);
    check("reset cd",      bus.cd,      0);
    check("reset winner",  bus.winner,  0);
    check("reset score_l", bus.score_l, 0);
    check("reset score_r", bus.score_r, 0);

    //             l  r  s  sl nw   st pos cd wn scl scr leds
    vecs[0]  = '{0, 0, 1, 0, 0,  0, 4, 0, 0, 0, 0, OH4};
    vecs[1]  = '{0, 0, 0, 0, 0,  0, 4, 0, 0, 0, 0, OH4};
    vecs[2]  = '{0, 0, 0, 0, 0,  1, 4, 3, 0, 0, 0, OH4};
    vecs[3]  = '{0, 0, 0, 1, 0,  1, 4, 2, 0, 0, 0, OH4};
    vecs[4]  = '{0, 0, 0, 0, 8,  1, 4, 2, 0, 0, 0, OH4};
    vecs[5]  = '{0, 0, 0, 1, 0,  1, 4, 1, 0, 0, 0, OH4};
    vecs[6]  = '{0, 0, 0, 0, 8,  1, 4, 1, 0, 0, 0, OH4};
    vecs[7]  = '{0, 0, 0, 1, 0,  2, 4, 0, 0, 0, 0, OH4};
    vecs[8]  = '{1, 0, 0, 0, 0,  2, 4, 0, 0, 0, 0, OH4};
    vecs[9]  = '{0, 0, 0, 0, 0,  2, 4, 0, 0, 0, 0, OH4};
    vecs[10] = '{0, 0, 0, 0, 0,  2, 5, 0, 0, 0, 0, 9'b000100000};
    vecs[11] = '{1, 0, 0, 0, 2,  2, 6, 0, 0, 0, 0, 9'b001000000};
    vecs[12] = '{1, 0, 0, 0, 2,  2, 7, 0, 0, 0, 0, 9'b010000000};
    vecs[13] = '{1, 0, 0, 0, 2,  3, 8, 0, 1, 1, 0, ALL1};
    vecs[14] = '{0, 0, 0, 1, 0,  3, 8, 0, 1, 1, 0, ALL0};
    vecs[15] = '{0, 0, 0, 1, 0,  3, 8, 0, 1, 1, 0, ALL1};
    vecs[16] = '{0, 0, 0, 1, 0,  3, 8, 0, 1, 1, 0, ALL0};
    vecs[17] = '{0, 0, 0, 1, 0,  0, 4, 0, 1, 1, 0, OH4};
    vecs[18] = '{0, 0, 1, 0, 2,  1, 4, 3, 0, 1, 0, OH4};
    vecs[19] = '{0, 0, 0, 1, 0,  1, 4, 2, 0, 1, 0, OH4};
    vecs[20] = '{0, 0, 0, 1, 0,  1, 4, 1, 0, 1, 0, OH4};
    vecs[21] = '{0, 0, 0, 1, 0,  2, 4, 0, 0, 1, 0, OH4};
    vecs[22] = '{1, 1, 0, 0, 4,  2, 4, 0, 0, 1, 0, OH4};

    for (int i = 0; i < 23; i++) begin
      press(vecs[i].l, vecs[i].r, vecs[i].s, vecs[i].slw, vecs[i].nw);
      check($sformatf("row%0d state", i),   bus.state,   vecs[i].st);
      check($sformatf("row%0d pos", i),     bus.pos,     vecs[i].ps);
      check($sformatf("row%0d cd", i),      bus.cd,      vecs[i].cd);
      check($sformatf("row%0d winner", i),  bus.winner,  vecs[i].wn);
      check($sformatf("row%0d score_l", i), bus.score_l, vecs[i].scl);
      check($sformatf("row%0d score_r", i), bus.score_r, vecs[i].scr);
      check($sformatf("row%0d leds", i),    bus.leds,    vecs[i].led);
    end

    // A held button steps the rope exactly once.
    repeat (20) tick(1, 0, 0, 0);
    check("held pos", bus.pos, 5);
    repeat (3) tick(0, 0, 0, 0);
    check("held release pos", bus.pos, 5);

    // Right player pulls from 5 to 0 and wins.
    for (int i = 0; i < 5; i++) begin
      press(0, 1, 0, 0, 2);
      check($sformatf("rwin step%0d pos", i), bus.pos, 4 - i);
    end
    check("rwin state",   bus.state,   S_WIN);
    check("rwin winner",  bus.winner,  2);
    check("rwin score_r", bus.score_r, 1);
    repeat (WIN_TICKS) tick(0, 0, 0, 1);
    check("rwin idle", bus.state, S_IDLE);

    // False starts clamp at 1 and never leave COUNTDOWN.
    press(0, 0, 1, 0, 2);
    for (int i = 0; i < 5; i++) begin
      press(1, 0, 0, 0, 2);
      check($sformatf("clamp%0d pos", i),   bus.pos,   imax(1, 3 - i));
      check($sformatf("clamp%0d state", i), bus.state, S_CD);
    end
    repeat (COUNT_TICKS) tick(0, 0, 0, 1);
    check("clamp play state", bus.state, S_PLAY);
    check("clamp play pos",   bus.pos,   1);

    // Saturating right score over 16 more wins.
    for (int i = 0; i < 16; i++) begin
      int n;
      n = 0;
      while (bus.state != 2'd3 && n < 10) begin
        press(0, 1, 0, 0, 2);
        n++;
      end
      check($sformatf("sat%0d in win", i), bus.state, S_WIN);
      check($sformatf("sat%0d score_r", i), bus.score_r, imin(15, i + 2));
      if (i < 15) begin
        repeat (WIN_TICKS) tick(0, 0, 0, 1);
        start_game($sformatf("sat%0d", i));
      end
    end

    // Reset during WIN aborts everything on the next edge.
    rst = 0;
    tick(0, 0, 0, 0);
    rst = 1;
    check("midrst state",   bus.state,   0);
    check("midrst pos",     bus.pos,     CTR);
    check("midrst leds",    bus.leds,    OH4);
    check("midrst cd",      bus.cd,      0);
    check("midrst winner",  bus.winner,  0);
    check("midrst score_l", bus.score_l, 0);
    check("midrst score_r", bus.score_r, 0);

    // Random play against the model.
    begin
      bit rl, rr, rs;
      rl = 0; rr = 0; rs = 0;
      rst = 0;
      tick(0, 0, 0, 0);
      rst = 1;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 2) == 0) rl = ~rl;
        if ($urandom_range(0, 3) == 0) rr = ~rr;
        if ($urandom_range(0, 5) == 0) rs = ~rs;
        rst = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
        tick(rl, rr, rs, $urandom_range(0, 4) == 0);
        check_model(c);
      end
      rst = 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
